// File: rtl/gpio_bidir_controller.sv
// Avalon-MM GPIO port: WIDTH bidirectional bits with atomic set/clear, synchronised inputs,
// per-bit sticky edge capture and a maskable level interrupt.
module gpio_bidir_controller #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] pin_d_q;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rd_val;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign pin_s        = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = pin_s & ~pin_d_q;
            1:       edge_det = ~pin_s & pin_d_q;
            default: edge_det = pin_s ^ pin_d_q;
        endcase
    end

    // Register writes; a capture in the same cycle as a W1C keeps the bit set.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        edge_cap_d = edge_cap_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out_d = wdata;
                ADDR_DIR:    dir_d      = wdata;
                ADDR_MASK:   mask_d     = wdata;
                ADDR_EDGE:   edge_cap_d = edge_cap_q & ~wdata;
                ADDR_OUTSET: data_out_d = data_out_q | wdata;
                ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
                default:     ;
            endcase
        end
        edge_cap_d = edge_cap_d | edge_det;
        irq_d      = |(edge_cap_q & mask_q);
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:   rd_val = (dir_q & data_out_q) | (~dir_q & pin_s);
            ADDR_DIR:    rd_val = dir_q;
            ADDR_MASK:   rd_val = mask_q;
            ADDR_EDGE:   rd_val = edge_cap_q;
            ADDR_OUTSET: rd_val = data_out_q;
            ADDR_OUTCLR: rd_val = data_out_q;
            default:     rd_val = '0;
        endcase
        readdata_d = readdata_q;
        if (chipselect) begin
            readdata_d             = '0;
            readdata_d[WIDTH-1:0]  = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            mask_q     <= '0;
            edge_cap_q <= '0;
            pin_d_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            pin_d_q    <= pin_s;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            sync_q[0]  <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bidir_controller.sv
// Directed bench: rising-edge instance (RESET_VALUE=A5) and any-edge instance on a shared bus.
module tb_gpio_bidir_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, readdata2;
    logic [7:0]  in_port, in_port2;
    logic [7:0]  out_port, out_port2;
    logic [7:0]  oe, oe2;
    logic        irq, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_bidir_controller #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .out_port(out_port),
        .oe(oe), .irq(irq)
    );

    gpio_bidir_controller #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata2), .in_port(in_port2), .out_port(out_port2),
        .oe(oe2), .irq(irq2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d2);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        d  = readdata;
        d2 = readdata2;
    endtask

    task automatic test_reset();
        logic [31:0] r, r2;
        reset = 1'b1; in_port = 8'h3C;
        tick(3);
        n_checks++; if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out_port: got %h want a5", out_port); end
        n_checks++; if (oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe: got %h want 00", oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", readdata); end
        reset = 1'b0;
        tick(3);
        bus_read(3'd0, r, r2);
        n_checks++; if (r !== 32'h0000003C) begin n_fail++; $display("FAIL read_pins: got %h want 0000003c", r); end
        address = 3'd1;
        tick(2);
        n_checks++; if (readdata !== 32'h0000003C) begin n_fail++; $display("FAIL readdata_hold: got %h want 0000003c", readdata); end
    endtask

    task automatic test_dir_data();
        logic [31:0] r, r2;
        bus_write(3'd1, 32'h000000F0);
        bus_write(3'd0, 32'h000000FF);
        in_port = 8'h00;
        n_checks++; if (out_port !== 8'hFF) begin n_fail++; $display("FAIL data_out_port: got %h want ff", out_port); end
        n_checks++; if (oe !== 8'hF0) begin n_fail++; $display("FAIL dir_oe: got %h want f0", oe); end
        tick(3);
        bus_read(3'd0, r, r2);
        n_checks++; if (r !== 32'h000000F0) begin n_fail++; $display("FAIL read_mixed: got %h want 000000f0", r); end
        bus_write(3'd1, 32'h123456F0);
        bus_read(3'd1, r, r2);
        n_checks++; if (r !== 32'h000000F0) begin n_fail++; $display("FAIL dir_upper_bits: got %h want 000000f0", r); end
        bus_write(3'd6, 32'hFFFFFFFF);
        bus_read(3'd6, r, r2);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL read_addr6: got %h want 0", r); end
        bus_read(3'd7, r, r2);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL read_addr7: got %h want 0", r); end
        n_checks++; if (out_port !== 8'hFF) begin n_fail++; $display("FAIL addr6_ignored: got %h want ff", out_port); end
    endtask

    task automatic test_set_clr();
        logic [31:0] r, r2;
        bus_write(3'd0, 32'h000000F0);
        bus_write(3'd4, 32'h00000001);
        n_checks++; if (out_port !== 8'hF1) begin n_fail++; $display("FAIL outset: got %h want f1", out_port); end
        bus_read(3'd4, r, r2);
        n_checks++; if (r !== 32'h000000F1) begin n_fail++; $display("FAIL read_outset: got %h want 000000f1", r); end
        bus_write(3'd5, 32'h00000080);
        n_checks++; if (out_port !== 8'h71) begin n_fail++; $display("FAIL outclr: got %h want 71", out_port); end
        bus_read(3'd5, r, r2);
        n_checks++; if (r !== 32'h00000071) begin n_fail++; $display("FAIL read_outclr: got %h want 00000071", r); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] r, r2;
        bus_write(3'd3, 32'h000000FF);
        bus_write(3'd2, 32'h00000004);
        bus_read(3'd2, r, r2);
        n_checks++; if (r !== 32'h00000004) begin n_fail++; $display("FAIL read_mask: got %h want 00000004", r); end
        in_port = 8'h04;
        tick(3);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_capture: got %b want 0", irq); end
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h00000004) begin n_fail++; $display("FAIL edge_rise_bit2: got %h want 00000004", r); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise: got %b want 1", irq); end
        bus_write(3'd3, 32'h00000004);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_registered: got %b want 1", irq); end
        tick(1);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
        in_port = 8'h0C;
        tick(3);
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h00000008) begin n_fail++; $display("FAIL edge_masked_bit3: got %h want 00000008", r); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
    endtask

    task automatic test_set_wins();
        logic [31:0] r, r2;
        bus_write(3'd3, 32'h000000FF);
        in_port = 8'h0E;
        tick(2);
        bus_write(3'd3, 32'h00000002);
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h00000002) begin n_fail++; $display("FAIL set_wins_w1c: got %h want 00000002", r); end
        n_checks++; if (r2 !== 32'h0) begin n_fail++; $display("FAIL any_edge_idle: got %h want 0", r2); end
    endtask

    task automatic test_any_edge();
        logic [31:0] r, r2;
        bus_write(3'd3, 32'h000000FF);
        in_port2 = 8'h01;
        tick(4);
        in_port2 = 8'h00;
        tick(4);
        bus_read(3'd3, r, r2);
        n_checks++; if (r2 !== 32'h00000001) begin n_fail++; $display("FAIL any_edge_pulse: got %h want 00000001", r2); end
        bus_write(3'd3, 32'h000000FF);
        in_port = 8'h0A;
        tick(4);
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rise_ignores_fall: got %h want 0", r); end
        n_checks++; if (r2 !== 32'h0) begin n_fail++; $display("FAIL any_edge_quiet: got %h want 0", r2); end
        in_port2 = 8'h01;
        tick(4);
        bus_write(3'd3, 32'h00000001);
        in_port2 = 8'h00;
        tick(4);
        bus_read(3'd3, r, r2);
        n_checks++; if (r2 !== 32'h00000001) begin n_fail++; $display("FAIL any_edge_fall: got %h want 00000001", r2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, r2;
        in_port = 8'h00;
        tick(4);
        bus_write(3'd3, 32'h000000FF);
        bus_write(3'd2, 32'h000000FF);
        in_port = 8'hFF;
        tick(3);
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h000000FF) begin n_fail++; $display("FAIL edge_all: got %h want 000000ff", r); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_all: got %b want 1", irq); end
        reset = 1'b1; in_port = 8'h00;
        tick(1);
        reset = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
        n_checks++; if (out_port !== 8'hA5) begin n_fail++; $display("FAIL mid_reset_out: got %h want a5", out_port); end
        n_checks++; if (oe !== 8'h00) begin n_fail++; $display("FAIL mid_reset_oe: got %h want 00", oe); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_readdata: got %h want 0", readdata); end
        tick(3);
        bus_read(3'd3, r, r2);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL mid_reset_edge: got %h want 0", r); end
        bus_read(3'd2, r, r2);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL mid_reset_mask: got %h want 0", r); end
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in_port = '0; in_port2 = '0;
        test_reset();
        test_dir_data();
        test_set_clr();
        test_edge_irq();
        test_set_wins();
        test_any_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
